// File: rtl/regfile_write_arbiter.sv
// Merges the ALU and load writeback streams into one register-file write port.
// Each requester has a one-entry buffer. Writes to x0 are dropped and counted.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_REG,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    input  logic              B_VALID,
    input  logic [ADDR_W-1:0] B_REG,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    output logic              WRITE,
    output logic [ADDR_W-1:0] WRITE_REG,
    output logic [DATA_W-1:0] WRITE_DATA,
    output logic [31:0]       PENDING,
    output logic [7:0]        DROP_CNT
);

    logic              r_a_full;
    logic [ADDR_W-1:0] r_a_reg;
    logic [DATA_W-1:0] r_a_data;
    logic              r_a_ord;
    logic              r_b_full;
    logic [ADDR_W-1:0] r_b_reg;
    logic [DATA_W-1:0] r_b_data;
    logic              r_b_ord;
    logic              r_last_b;
    logic              r_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic [7:0]        r_drop_cnt;

    logic       w_a_xfer;
    logic       w_b_xfer;
    logic       w_a_fill;
    logic       w_b_fill;
    logic       w_a_drop;
    logic       w_b_drop;
    logic       w_both;
    logic       w_a_older;
    logic       w_grant_a;
    logic       w_grant_b;
    logic [8:0] w_drop_sum;
    logic [31:0] w_pending;

    assign A_READY  = !r_a_full && !RST;
    assign B_READY  = !r_b_full && !RST;

    assign w_a_xfer = A_VALID && A_READY;
    assign w_b_xfer = B_VALID && B_READY;
    assign w_a_fill = w_a_xfer && (A_REG != '0);
    assign w_b_fill = w_b_xfer && (B_REG != '0);
    assign w_a_drop = w_a_xfer && (A_REG == '0);
    assign w_b_drop = w_b_xfer && (B_REG == '0);

    // An order bit of 1 marks the younger entry; equal bits mean a same-edge fill, A wins.
    assign w_both    = r_a_full && r_b_full;
    assign w_a_older = !(r_a_ord && !r_b_ord);
    assign w_grant_a = r_a_full &&
                       (!r_b_full || ((r_a_reg == r_b_reg) ? w_a_older : r_last_b));
    assign w_grant_b = r_b_full && !w_grant_a;

    assign w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_a_drop) + 9'(w_b_drop);

    always_comb begin
        w_pending = '0;
        for (int i = 1; i < 32; i++) begin
            w_pending[i] = (r_a_full && (r_a_reg == ADDR_W'(i))) ||
                           (r_b_full && (r_b_reg == ADDR_W'(i))) ||
                           (r_write && (r_write_reg == ADDR_W'(i)));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a_full     <= 1'b0;
            r_a_reg      <= '0;
            r_a_data     <= '0;
            r_a_ord      <= 1'b0;
            r_b_full     <= 1'b0;
            r_b_reg      <= '0;
            r_b_data     <= '0;
            r_b_ord      <= 1'b0;
            r_last_b     <= 1'b1;
            r_write      <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_a_fill) begin
                r_a_full <= 1'b1;
                r_a_reg  <= A_REG;
                r_a_data <= A_DATA;
                r_a_ord  <= r_b_full && !w_grant_b;
            end else if (w_grant_a) begin
                r_a_full <= 1'b0;
            end else if (w_grant_b) begin
                r_a_ord  <= 1'b0;
            end

            if (w_b_fill) begin
                r_b_full <= 1'b1;
                r_b_reg  <= B_REG;
                r_b_data <= B_DATA;
                r_b_ord  <= r_a_full && !w_grant_a;
            end else if (w_grant_b) begin
                r_b_full <= 1'b0;
            end else if (w_grant_a) begin
                r_b_ord  <= 1'b0;
            end

            // Round-robin pointer only moves when both requesters competed.
            if (w_both) begin
                r_last_b <= w_grant_b;
            end

            r_write <= w_grant_a || w_grant_b;
            if (w_grant_a) begin
                r_write_reg  <= r_a_reg;
                r_write_data <= r_a_data;
            end else if (w_grant_b) begin
                r_write_reg  <= r_b_reg;
                r_write_data <= r_b_data;
            end

            r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
        end
    end

    assign WRITE      = r_write;
    assign WRITE_REG  = r_write_reg;
    assign WRITE_DATA = r_write_data;
    assign PENDING    = w_pending;
    assign DROP_CNT   = r_drop_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus streaming, x0 and reset sequences.
module tb_regfile_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        A_VALID = 1'b0;
    logic [4:0]  A_REG = '0;
    logic [31:0] A_DATA = '0;
    logic        A_READY;
    logic        B_VALID = 1'b0;
    logic [4:0]  B_REG = '0;
    logic [31:0] B_DATA = '0;
    logic        B_READY;
    logic        WRITE;
    logic [4:0]  WRITE_REG;
    logic [31:0] WRITE_DATA;
    logic [31:0] PENDING;
    logic [7:0]  DROP_CNT;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(B_READY),
        .WRITE(WRITE), .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA),
        .PENDING(PENDING), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        wr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] pend;
        logic        ardy;
        logic        brdy;
        logic [7:0]  drop;
    } vec_t;

    vec_t        vecs[22];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic bv, input logic [4:0] br, input logic [31:0] bd,
                                input logic wr, input logic [4:0] wreg, input logic [31:0] wdata,
                                input logic [31:0] pend, input logic ardy, input logic brdy,
                                input logic [7:0] drop);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.wr = wr; v.wreg = wreg; v.wdata = wdata; v.pend = pend;
        v.ardy = ardy; v.brdy = brdy; v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic take_write();
        if (WRITE) begin
            n_wr++;
            if (WRITE_REG == 5'd12 && qa.size() != 0) begin
                chk("stream A data", WRITE_DATA, qa.pop_front());
            end else if (WRITE_REG == 5'd13 && qb.size() != 0) begin
                chk("stream B data", WRITE_DATA, qb.pop_front());
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL stream unexpected write: reg %0d data 0x%0h, expected a queued write",
                         WRITE_REG, WRITE_DATA);
            end
        end
    endtask

    initial begin
        //             A request        B request        expected after the edge
        vecs[0]  = mk(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 32'h0,  32'h018, 0, 0, 0);
        vecs[1]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 3, 32'h11, 32'h018, 1, 0, 0);
        vecs[2]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 4, 32'h22, 32'h010, 1, 1, 0);
        vecs[3]  = mk(1, 3, 32'h33, 1, 4, 32'h44, 0, 4, 32'h22, 32'h018, 0, 0, 0);
        vecs[4]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 4, 32'h44, 32'h018, 0, 1, 0);
        vecs[5]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 3, 32'h33, 32'h008, 1, 1, 0);
        vecs[6]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 3, 32'h33, 32'h000, 1, 1, 0);
        vecs[7]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0, 0, 3, 32'h33, 32'h020, 0, 1, 0);
        vecs[8]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 5, 32'hDEADBEEF, 32'h020, 1, 1, 0);
        vecs[9]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 5, 32'hDEADBEEF, 32'h000, 1, 1, 0);
        vecs[10] = mk(0, 0, 32'h0,  1, 7, 32'hAA, 0, 5, 32'hDEADBEEF, 32'h080, 1, 0, 0);
        vecs[11] = mk(1, 7, 32'hBB, 0, 0, 32'h0,  1, 7, 32'hAA, 32'h080, 0, 1, 0);
        vecs[12] = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 7, 32'hBB, 32'h080, 1, 1, 0);
        vecs[13] = mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 7, 32'hBB, 32'h000, 1, 1, 0);
        vecs[14] = mk(1, 10, 32'h55, 1, 11, 32'h66, 0, 7, 32'hBB, 32'hC00, 0, 0, 0);
        vecs[15] = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 10, 32'h55, 32'hC00, 1, 0, 0);
        vecs[16] = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 11, 32'h66, 32'h800, 1, 1, 0);
        vecs[17] = mk(1, 9, 32'h77, 1, 9, 32'h88, 0, 11, 32'h66, 32'h200, 0, 0, 0);
        vecs[18] = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 9, 32'h77, 32'h200, 1, 0, 0);
        vecs[19] = mk(0, 0, 32'h0,  0, 0, 32'h0,  1, 9, 32'h88, 32'h200, 1, 1, 0);
        vecs[20] = mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 9, 32'h88, 32'h000, 1, 1, 0);
        vecs[21] = mk(1, 0, 32'h1,  1, 0, 32'h2,  0, 9, 32'h88, 32'h000, 1, 1, 2);

        repeat (2) @(posedge CLK);
        #1;
        chk("reset WRITE", {31'b0, WRITE}, 32'h0);
        chk("reset WRITE_REG", {27'b0, WRITE_REG}, 32'h0);
        chk("reset WRITE_DATA", WRITE_DATA, 32'h0);
        chk("reset PENDING", PENDING, 32'h0);
        chk("reset A_READY", {31'b0, A_READY}, 32'h0);
        chk("reset B_READY", {31'b0, B_READY}, 32'h0);
        chk("reset DROP_CNT", {24'b0, DROP_CNT}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 22; i++) begin
            A_VALID = vecs[i].av; A_REG = vecs[i].ar; A_DATA = vecs[i].ad;
            B_VALID = vecs[i].bv; B_REG = vecs[i].br; B_DATA = vecs[i].bd;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d WRITE", i), {31'b0, WRITE}, {31'b0, vecs[i].wr});
            chk($sformatf("v%0d WRITE_REG", i), {27'b0, WRITE_REG}, {27'b0, vecs[i].wreg});
            chk($sformatf("v%0d WRITE_DATA", i), WRITE_DATA, vecs[i].wdata);
            chk($sformatf("v%0d PENDING", i), PENDING, vecs[i].pend);
            chk($sformatf("v%0d A_READY", i), {31'b0, A_READY}, {31'b0, vecs[i].ardy});
            chk($sformatf("v%0d B_READY", i), {31'b0, B_READY}, {31'b0, vecs[i].brdy});
            chk($sformatf("v%0d DROP_CNT", i), {24'b0, DROP_CNT}, {24'b0, vecs[i].drop});
        end

        // Both requesters streaming: one write per cycle, per-register order preserved.
        begin
            int na = 0;
            int nb = 0;
            A_VALID = 1'b1; B_VALID = 1'b1; A_REG = 5'd12; B_REG = 5'd13;
            for (int k = 1; k <= 20; k++) begin
                bit pa;
                bit pb;
                A_DATA = 32'h1000 + 32'(na);
                B_DATA = 32'h2000 + 32'(nb);
                pa = A_READY;
                pb = B_READY;
                if (pa) qa.push_back(A_DATA);
                if (pb) qb.push_back(B_DATA);
                @(posedge CLK);
                #1;
                if (pa) na++;
                if (pb) nb++;
                if (k >= 2) chk($sformatf("stream k%0d WRITE", k), {31'b0, WRITE}, 32'h1);
                take_write();
            end
            A_VALID = 1'b0; B_VALID = 1'b0;
            repeat (3) begin
                @(posedge CLK);
                #1;
                take_write();
            end
            chk("stream write count", 32'(n_wr), 32'd20);
            chk("stream A drained", 32'(qa.size()), 32'd0);
            chk("stream B drained", 32'(qb.size()), 32'd0);
            chk("stream PENDING idle", PENDING, 32'h0);
        end

        // x0 filter: 300 writes to reg 0, counter starts at 2 from the table.
        A_VALID = 1'b1; A_REG = 5'd0; A_DATA = 32'h5A5A;
        for (int k = 0; k < 300; k++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("x0 k%0d WRITE", k), {31'b0, WRITE}, 32'h0);
            chk($sformatf("x0 k%0d PENDING", k), PENDING, 32'h0);
            if (k == 99) chk("x0 DROP_CNT mid", {24'b0, DROP_CNT}, 32'd102);
        end
        A_VALID = 1'b0;
        chk("x0 DROP_CNT saturated", {24'b0, DROP_CNT}, 32'd255);

        // Reset with a write on the output and a buffered entry behind it.
        A_VALID = 1'b1; A_REG = 5'd14; A_DATA = 32'hE1;
        B_VALID = 1'b1; B_REG = 5'd15; B_DATA = 32'hF1;
        @(posedge CLK);
        #1;
        A_VALID = 1'b0; B_VALID = 1'b0;
        @(posedge CLK);
        #1;
        chk("pre-reset WRITE", {31'b0, WRITE}, 32'h1);
        chk("pre-reset PENDING", PENDING, 32'h0000_C000);
        #2;
        RST = 1'b1;
        #1;
        chk("mid-reset WRITE", {31'b0, WRITE}, 32'h0);
        chk("mid-reset PENDING", PENDING, 32'h0);
        chk("mid-reset A_READY", {31'b0, A_READY}, 32'h0);
        chk("mid-reset B_READY", {31'b0, B_READY}, 32'h0);
        chk("mid-reset DROP_CNT", {24'b0, DROP_CNT}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("post-reset no stale WRITE", {31'b0, WRITE}, 32'h0);
            chk("post-reset PENDING", PENDING, 32'h0);
        end
        A_VALID = 1'b1; A_REG = 5'd6; A_DATA = 32'hCAFE;
        @(posedge CLK);
        #1;
        A_VALID = 1'b0;
        chk("post-reset buffered PENDING", PENDING, 32'h40);
        chk("post-reset buffered WRITE", {31'b0, WRITE}, 32'h0);
        @(posedge CLK);
        #1;
        chk("post-reset WRITE", {31'b0, WRITE}, 32'h1);
        chk("post-reset WRITE_REG", {27'b0, WRITE_REG}, 32'd6);
        chk("post-reset WRITE_DATA", WRITE_DATA, 32'hCAFE);
        chk("post-reset A_READY", {31'b0, A_READY}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_W, 32, write-data width.
- ADDR_W, 5, register-index width (32 registers).
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock; all state updates on rising edge.
- RST, in, 1, asynchronous active-high reset.
- A_VALID, in, 1, requester A (ALU writeback) write request.
- A_REG, in, ADDR_W, requester A destination register.
- A_DATA, in, DATA_W, requester A write data.
- A_READY, out, 1, requester A slot free.
- B_VALID, in, 1, requester B (load writeback) write request.
- B_REG, in, ADDR_W, requester B destination register.
- B_DATA, in, DATA_W, requester B write data.
- B_READY, out, 1, requester B slot free.
- WRITE, out, 1, register-file write enable, one cycle per write.
- WRITE_REG, out, ADDR_W, register-file destination index.
- WRITE_DATA, out, DATA_W, register-file write data.
- PENDING, out, 32, bit r set while a write to register r is buffered or on the output.
- DROP_CNT, out, 8, count of discarded x0 writes.
REQ-003 The clock SHALL be CLK, and the reset SHALL be RST: one clock, asynchronous, active-high.

Function
REQ-004 Each requester SHALL own a one-entry buffer (full flag, reg, data, arrival-order bit).
REQ-005 X_READY SHALL equal NOT buffer-full AND NOT RST, combinationally.
REQ-006 A transfer SHALL occur on a rising edge where X_VALID and X_READY are both 1; the buffer is full from that edge.
REQ-007 A transfer with X_REG = 0 SHALL NOT fill the buffer; DROP_CNT SHALL increment, saturating at 255.
REQ-008 On each edge with at least one buffer full, exactly one buffer SHALL be granted and emptied at that edge.
REQ-009 With one buffer full, that buffer SHALL be granted.
REQ-010 With both buffers full and different registers, grant SHALL be round-robin: the requester not granted last; LAST initialises to B, so A wins first.
REQ-011 With both buffers full and the same register, the older entry SHALL be granted; if both filled at the same edge, A SHALL be treated as older.
REQ-012 The grant edge SHALL register WRITE=1 with the granted WRITE_REG and WRITE_DATA; WRITE SHALL be 0 after any edge without a grant.
REQ-013 Latency SHALL be fixed. After transfer at edge N with no contention, the grant occurs at edge N+1 and WRITE is high from N+1 to N+2. X_READY is high again after edge N+1.
REQ-014 The grant edge SHALL free the buffer, but a new transfer SHALL be accepted only when X_READY was 1 before the edge: no same-edge refill, so peak rate is one transfer per requester every 2 cycles.
REQ-015 With both requesters streaming, aggregate output SHALL be one WRITE per cycle, with no buffered write lost or reordered per register.
REQ-016 WRITE_REG/WRITE_DATA SHALL hold their last values when WRITE=0.
REQ-017 PENDING SHALL be combinational: the OR of decoded full-buffer registers plus WRITE_REG while WRITE=1; bit 0 is always 0.

Reset
REQ-018 While RST=1: both buffers SHALL be empty; WRITE, WRITE_REG, WRITE_DATA, PENDING and DROP_CNT SHALL be 0; A_READY/B_READY SHALL be 0; LAST SHALL be B.
REQ-019 Reset asserted mid-operation SHALL discard buffered and in-flight writes immediately, without completing them.
REQ-020 The first transfer SHALL be possible on the first rising edge after RST deasserts.

Verification
REQ-021 A single write: A writes reg 5, data 0xDEADBEEF at edge N. Expect WRITE=1, WRITE_REG=5 and WRITE_DATA=0xDEADBEEF after edge N+1. PENDING[5]=1 from N until N+2. A_READY=1 after N+1.
REQ-022 Contention on different registers: A reg 3 / 0x11 and B reg 4 / 0x22 at the same edge N. Expect reg 3 written at N+1 and reg 4 at N+2. Repeating the pair next time grants B first.
REQ-023 Same register: B reg 7 / 0xAA is accepted at N, and A reg 7 / 0xBB at N+1 while LAST=B. Expect 0xAA written before 0xBB.
REQ-024 x0 filter: 300 A writes to reg 0. Expect WRITE never asserts, PENDING=0 and DROP_CNT saturates at 255.
REQ-025 Reset mid-operation: both buffers full, then RST pulses. Expect WRITE=0, PENDING=0 and READY=0 immediately. After release, no stale write appears, and a new write completes with nominal latency.
